// File: rtl/pingpong_bank_ctrl_pkg.sv
// Shared constants and helpers for the ping-pong sub-block buffer sequencer.
package pingpong_bank_ctrl_pkg;

   localparam int unsigned DEPTH_DEFAULT = 16;
   localparam int unsigned SUB_BLOCK_W   = 64;
   localparam int unsigned NUM_BANKS     = 2;

   typedef logic [NUM_BANKS-1:0] bank_flags_t;

   // Mod-depth successor of a slot index; wraps at depth-1, not at a power of two.
   function automatic int unsigned next_slot(input int unsigned cur, input int unsigned depth);
      return (cur == depth - 1) ? 0 : cur + 1;
   endfunction

endpackage

// File: rtl/pingpong_bank_ctrl_if.sv
// Writer/consumer handshake bundle between the ping-pong sequencer and its clients.
interface pingpong_bank_ctrl_if #(
   parameter int unsigned DEPTH = pingpong_bank_ctrl_pkg::DEPTH_DEFAULT,
   parameter int unsigned AW    = $clog2(DEPTH)
) ();

   logic          wr_req;
   logic          wr_gnt;
   logic          wr_bank;
   logic [AW-1:0] wr_addr;
   logic          rd_req;
   logic          rd_gnt;
   logic          sel;
   logic [AW-1:0] rd_addr;
   logic          out_valid;
   logic          rd_last;
   logic [1:0]    bank_full;

   modport master (
      output wr_req, rd_req,
      input  wr_gnt, wr_bank, wr_addr, rd_gnt, sel, rd_addr, out_valid, rd_last, bank_full
   );

   modport slave (
      input  wr_req, rd_req,
      output wr_gnt, wr_bank, wr_addr, rd_gnt, sel, rd_addr, out_valid, rd_last, bank_full
   );

endinterface

// File: rtl/pingpong_bank_ctrl_bank_side_cnt.sv
// One side (writer or reader) of the ping-pong buffer: mod-DEPTH slot counter plus bank toggle.
module bank_side_cnt
   import pingpong_bank_ctrl_pkg::*;
#(
   parameter int unsigned DEPTH = DEPTH_DEFAULT,
   parameter int unsigned AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          flush,
   input  logic          en,
   output logic [AW-1:0] addr,
   output logic          bank,
   output logic          wrap_c
);

   logic [AW-1:0] addr_nxt;

   assign wrap_c   = en && (addr == AW'(DEPTH - 1));
   assign addr_nxt = AW'(next_slot(32'(addr), DEPTH));

   // Slot advances on every enabled cycle; the bank flips only on the last slot.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         addr <= '0;
         bank <= 1'b0;
      end else if (flush) begin
         addr <= '0;
         bank <= 1'b0;
      end else if (en) begin
         addr <= addr_nxt;
         if (wrap_c) begin
            bank <= ~bank;
         end
      end
   end

endmodule

// File: rtl/pingpong_bank_ctrl.sv
// Ping-pong bank sequencer: grants the free bank to the writer, the filled bank to the consumer,
// and produces out_valid/rd_last aligned with the registered sub-block mux in front of the consumer.
module pingpong_bank_ctrl
   import pingpong_bank_ctrl_pkg::*;
#(
   parameter int unsigned DEPTH = DEPTH_DEFAULT,
   parameter int unsigned AW    = $clog2(DEPTH)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 flush,
   pingpong_bank_ctrl_if.slave  bus
);

   logic [AW-1:0] wr_addr;
   logic [AW-1:0] rd_addr;
   logic          wr_bank;
   logic          sel;
   logic          wr_wrap_c;
   logic          rd_wrap_c;
   logic          wr_gnt;
   logic          rd_gnt;
   logic          wr_fire;
   logic          rd_fire;
   logic          out_valid;
   logic          rd_last;
   bank_flags_t   full;
   bank_flags_t   full_nxt;

   // Grants are the only combinational outputs; flush suppresses both.
   assign wr_gnt  = !full[wr_bank] && !flush;
   assign rd_gnt  = full[sel] && !flush;
   assign wr_fire = bus.wr_req && wr_gnt;
   assign rd_fire = bus.rd_req && rd_gnt;

   bank_side_cnt #(.DEPTH(DEPTH), .AW(AW)) u_wr_side (
      .clk    (clk),
      .reset  (reset),
      .flush  (flush),
      .en     (wr_fire),
      .addr   (wr_addr),
      .bank   (wr_bank),
      .wrap_c (wr_wrap_c)
   );

   bank_side_cnt #(.DEPTH(DEPTH), .AW(AW)) u_rd_side (
      .clk    (clk),
      .reset  (reset),
      .flush  (flush),
      .en     (rd_fire),
      .addr   (rd_addr),
      .bank   (sel),
      .wrap_c (rd_wrap_c)
   );

   // Write completion sets its bank, read completion clears its bank; both may apply at once.
   always_comb begin
      full_nxt = full;
      if (wr_wrap_c) begin
         full_nxt[wr_bank] = 1'b1;
      end
      if (rd_wrap_c) begin
         full_nxt[sel] = 1'b0;
      end
   end

   // out_valid/rd_last track the one-cycle mux register latency.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         full      <= '0;
         out_valid <= 1'b0;
         rd_last   <= 1'b0;
      end else if (flush) begin
         full      <= '0;
         out_valid <= 1'b0;
         rd_last   <= 1'b0;
      end else begin
         full      <= full_nxt;
         out_valid <= rd_fire;
         rd_last   <= rd_wrap_c;
      end
   end

   // A bank cannot be filling and draining at once, so set and clear never collide.
   a_set_clear_disjoint: assert property (
      @(posedge clk) disable iff (!reset) !(wr_wrap_c && rd_wrap_c && (wr_bank == sel))
   );

   assign bus.wr_gnt    = wr_gnt;
   assign bus.wr_bank   = wr_bank;
   assign bus.wr_addr   = wr_addr;
   assign bus.rd_gnt    = rd_gnt;
   assign bus.sel       = sel;
   assign bus.rd_addr   = rd_addr;
   assign bus.out_valid = out_valid;
   assign bus.rd_last   = rd_last;
   assign bus.bank_full = full;

endmodule

// File: tb/tb_pingpong_bank_ctrl.sv
// Randomized bench for pingpong_bank_ctrl at DEPTH=16 and DEPTH=5 against a write/read-count model.
module tb_pingpong_bank_ctrl;

   logic clk;
   logic reset;
   logic flush;
   logic wr_req;
   logic rd_req;

   int n_tests;
   int n_fail;

   int dep[2] = '{16, 5};
   int w_cnt[2];
   int r_cnt[2];
   bit m_ov[2];
   bit m_last[2];
   int mem[2][2][16];
   int q_a[$];
   int q_b[$];

   int o_wr_bank[2], o_wr_addr[2], o_sel[2], o_rd_addr[2], o_full[2];
   int o_wgnt[2], o_rgnt[2], o_ov[2], o_last[2];
   bit e_wf[2], e_rf[2];
   int e_ra[2];

   pingpong_bank_ctrl_if #(.DEPTH(16)) bus_a ();
   pingpong_bank_ctrl_if #(.DEPTH(5))  bus_b ();

   assign bus_a.wr_req = wr_req;
   assign bus_a.rd_req = rd_req;
   assign bus_b.wr_req = wr_req;
   assign bus_b.rd_req = rd_req;

   pingpong_bank_ctrl #(.DEPTH(16)) dut_a (
      .clk   (clk),
      .reset (reset),
      .flush (flush),
      .bus   (bus_a)
   );

   pingpong_bank_ctrl #(.DEPTH(5)) dut_b (
      .clk   (clk),
      .reset (reset),
      .flush (flush),
      .bus   (bus_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input int got, input int exp);
      n_tests++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic void model_clear(input int i);
      w_cnt[i]  = 0;
      r_cnt[i]  = 0;
      m_ov[i]   = 1'b0;
      m_last[i] = 1'b0;
      if (i == 0) q_a.delete();
      else        q_b.delete();
   endfunction

   function automatic void grab(input int i);
      if (i == 0) begin
         o_wr_bank[0] = int'(bus_a.wr_bank);
         o_wr_addr[0] = int'(bus_a.wr_addr);
         o_sel[0]     = int'(bus_a.sel);
         o_rd_addr[0] = int'(bus_a.rd_addr);
         o_full[0]    = int'(bus_a.bank_full);
         o_wgnt[0]    = int'(bus_a.wr_gnt);
         o_rgnt[0]    = int'(bus_a.rd_gnt);
         o_ov[0]      = int'(bus_a.out_valid);
         o_last[0]    = int'(bus_a.rd_last);
      end else begin
         o_wr_bank[1] = int'(bus_b.wr_bank);
         o_wr_addr[1] = int'(bus_b.wr_addr);
         o_sel[1]     = int'(bus_b.sel);
         o_rd_addr[1] = int'(bus_b.rd_addr);
         o_full[1]    = int'(bus_b.bank_full);
         o_wgnt[1]    = int'(bus_b.wr_gnt);
         o_rgnt[1]    = int'(bus_b.rd_gnt);
         o_ov[1]      = int'(bus_b.out_valid);
         o_last[1]    = int'(bus_b.rd_last);
      end
   endfunction

   // Expected state follows from total writes/reads since the last clear.
   task automatic check_inst(input int i);
      int d, fw, fr, nf, ef, wg, rg;
      d  = dep[i];
      fw = w_cnt[i] / d;
      fr = r_cnt[i] / d;
      nf = fw - fr;
      ef = (nf == 0) ? 0 : (nf == 1) ? (1 << (fr % 2)) : 3;
      wg = (nf < 2 && !flush) ? 1 : 0;
      rg = (nf >= 1 && !flush) ? 1 : 0;
      grab(i);
      check($sformatf("wr_bank/d%0d", d),   o_wr_bank[i], fw % 2);
      check($sformatf("wr_addr/d%0d", d),   o_wr_addr[i], w_cnt[i] % d);
      check($sformatf("sel/d%0d", d),       o_sel[i],     fr % 2);
      check($sformatf("rd_addr/d%0d", d),   o_rd_addr[i], r_cnt[i] % d);
      check($sformatf("bank_full/d%0d", d), o_full[i],    ef);
      check($sformatf("wr_gnt/d%0d", d),    o_wgnt[i],    wg);
      check($sformatf("rd_gnt/d%0d", d),    o_rgnt[i],    rg);
      check($sformatf("out_valid/d%0d", d), o_ov[i],      int'(m_ov[i]));
      check($sformatf("rd_last/d%0d", d),   o_last[i],    int'(m_last[i]));
      e_wf[i] = wr_req && (wg == 1);
      e_rf[i] = rd_req && (rg == 1);
      e_ra[i] = r_cnt[i] % d;
   endtask

   task automatic update_inst(input int i);
      int d, data, exp_data;
      d = dep[i];
      if (!reset || flush) begin
         model_clear(i);
      end else begin
         if (e_rf[i]) begin
            exp_data = -1;
            if (i == 0 && q_a.size() > 0) exp_data = q_a.pop_front();
            if (i == 1 && q_b.size() > 0) exp_data = q_b.pop_front();
            check($sformatf("rd_data/d%0d", d), mem[i][o_sel[i] & 1][o_rd_addr[i] & 15], exp_data);
            r_cnt[i]++;
         end
         m_ov[i]   = e_rf[i];
         m_last[i] = e_rf[i] && (e_ra[i] == d - 1);
         if (e_wf[i]) begin
            data = int'($urandom_range(0, 32'h7fff_ffff));
            mem[i][o_wr_bank[i] & 1][o_wr_addr[i] & 15] = data;
            if (i == 0) q_a.push_back(data);
            else        q_b.push_back(data);
            w_cnt[i]++;
         end
      end
   endtask

   // Check on the falling edge, advance the model on the rising edge, return just after it.
   task automatic step();
      @(negedge clk);
      for (int i = 0; i < 2; i++) check_inst(i);
      @(posedge clk);
      for (int i = 0; i < 2; i++) update_inst(i);
      #1;
   endtask

   task automatic run(input int n, input int pw, input int pr);
      for (int k = 0; k < n; k++) begin
         flush  = 1'b0;
         wr_req = ($urandom_range(0, 99) < pw);
         rd_req = ($urandom_range(0, 99) < pr);
         step();
      end
   endtask

   // Reset asserted between edges must clear outputs before any clock edge.
   task automatic async_pulse();
      #2;
      reset = 1'b0;
      #1;
      for (int i = 0; i < 2; i++) model_clear(i);
      for (int i = 0; i < 2; i++) check_inst(i);
      wr_req = 1'b0;
      rd_req = 1'b0;
      step();
      step();
      reset = 1'b1;
   endtask

   initial begin
      int pw_tab[4] = '{25, 50, 90, 100};
      int pw, pr;
      n_tests = 0;
      n_fail  = 0;
      reset   = 1'b0;
      flush   = 1'b0;
      wr_req  = 1'b0;
      rd_req  = 1'b0;
      for (int i = 0; i < 2; i++) model_clear(i);

      repeat (2) step();
      reset = 1'b1;

      run(16, 100, 0);
      run(64, 100, 100);
      async_pulse();
      run(40, 100, 0);
      run(20, 100, 100);

      flush = 1'b1;
      step();
      run(16, 100, 0);
      run(4, 100, 0);
      run(3, 100, 100);
      flush  = 1'b1;
      wr_req = 1'b1;
      rd_req = 1'b1;
      step();
      run(10, 100, 100);

      for (int seg = 0; seg < 15; seg++) begin
         pw = pw_tab[$urandom_range(0, 3)];
         pr = pw_tab[$urandom_range(0, 3)];
         for (int k = 0; k < 100; k++) begin
            flush  = ($urandom_range(0, 299) == 0);
            wr_req = ($urandom_range(0, 99) < pw);
            rd_req = ($urandom_range(0, 99) < pr);
            step();
         end
         if (seg == 7) async_pulse();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
